userio_joy_scan: RTL and testbench

- Parametrised successor to the per-adapter UserIO serial joystick readers.
- Clocks a chain of parallel-in/serial-out shift registers (74HC165-style) on the UserIO port and assembles 1-4 player words of configurable width.
- Presents the player words as an active-high joystick bus with a frame-done strobe.
- Sits between the UserIO pins and the per-core joystick mux in emu, on the CLK_JOY domain.

---
 rtl/userio_joy_scan.sv | 184 ++++++++++++++++++
 tb/tb_userio_joy_scan.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/userio_joy_scan.sv
// userio_joy_scan
//   Scans a chain of 74HC165-style parallel-in/serial-out registers on the
//   UserIO port. It assembles NUM_PLAYERS words of BITS_PER_PLAYER buttons
//   each and presents them as an active-high joystick bus.
//
//   Optional build macro: USERIO_JOY_DEBOUNCE_EN
//     When defined, joystick only takes a new value once two consecutive
//     frames agree.
//
// Ports
//   clk          scan clock (CLK_JOY domain)
//   reset_n      asynchronous active-low reset
//   en           scanning enable (level)
//   joy_data     serial data from the chain, buttons active-low
//   joy_clk      shift clock to the chain
//   joy_load     parallel-load strobe to the chain, active-low
//   joystick     decoded buttons, active-high;
//                player p is at [p*BITS_PER_PLAYER +: BITS_PER_PLAYER]
//   frame_done   one-clk pulse when joystick may have updated
//   frame_cnt    completed-frame counter, wraps 255 -> 0
//   scan_active  high whenever the scanner is not idle
module userio_joy_scan #(
    parameter int NUM_PLAYERS     = 2,
    parameter int BITS_PER_PLAYER = 16,
    parameter int CLK_DIV         = 64,
    parameter int GAP_TICKS       = 32
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   en,
    input  logic                                   joy_data,
    output logic                                   joy_clk,
    output logic                                   joy_load,
    output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
    output logic                                   frame_done,
    output logic [7:0]                             frame_cnt,
    output logic                                   scan_active
);

    localparam int TOTAL = NUM_PLAYERS * BITS_PER_PLAYER;
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW    = $clog2(GAP_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SAMPLE,
        S_CLK_HI,
        S_LATCH,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [TOTAL-1:0]   sr_q, sr_d;
    logic [1:0]         sync_q, sync_d;
    logic [TOTAL-1:0]   joystick_q, joystick_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               joy_clk_q, joy_clk_d;
    logic               joy_load_q, joy_load_d;
    logic               scan_active_q, scan_active_d;
    logic               tick;
    logic               data_s;
    logic [IW-1:0]      idx_inc;
`ifdef USERIO_JOY_DEBOUNCE_EN
    logic [TOTAL-1:0]   prev_q, prev_d;
`endif

    // Prescaler free-runs regardless of en so tick phase is never disturbed.
    assign tick    = (presc_q == PW'(CLK_DIV - 1));
    assign data_s  = sync_q[1];
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        gap_d        = gap_q;
        sr_d         = sr_q;
        sync_d       = {sync_q[0], joy_data};
        joystick_d   = joystick_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
`ifdef USERIO_JOY_DEBOUNCE_EN
        prev_d       = prev_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (tick && en) state_d = S_LOAD;
            end
            S_LOAD: begin
                idx_d = '0;
                if (tick) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (tick) begin
                    // First bit shifted in ends up at sr[0] after TOTAL shifts.
                    sr_d  = {~data_s, sr_q[TOTAL-1:1]};
                    idx_d = idx_inc;
                    if (idx_inc == IW'(TOTAL)) state_d = S_LATCH;
                    else                       state_d = S_CLK_HI;
                end
            end
            S_CLK_HI: begin
                if (tick) state_d = S_SAMPLE;
            end
            S_LATCH: begin
`ifdef USERIO_JOY_DEBOUNCE_EN
                if (sr_q == prev_q) joystick_d = sr_q;
                prev_d = sr_q;
`else
                joystick_d = sr_q;
`endif
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 1'b1;
                gap_d        = '0;
                state_d      = S_GAP;
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_q == GW'(GAP_TICKS - 1)) state_d = en ? S_LOAD : S_IDLE;
                    else                             gap_d   = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin-level outputs are registered from the next state so they
        // switch cleanly on the same edge as the state register.
        joy_load_d    = (state_d != S_LOAD);
        joy_clk_d     = (state_d == S_CLK_HI);
        scan_active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            idx_q         <= '0;
            gap_q         <= '0;
            sr_q          <= '0;
            sync_q        <= '1;
            joystick_q    <= '0;
            frame_cnt_q   <= '0;
            frame_done_q  <= 1'b0;
            joy_clk_q     <= 1'b0;
            joy_load_q    <= 1'b1;
            scan_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            sr_q          <= sr_d;
            sync_q        <= sync_d;
            joystick_q    <= joystick_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_done_q  <= frame_done_d;
            joy_clk_q     <= joy_clk_d;
            joy_load_q    <= joy_load_d;
            scan_active_q <= scan_active_d;
        end
    end

`ifdef USERIO_JOY_DEBOUNCE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= '0;
        else          prev_q <= prev_d;
    end
`endif

    assign joy_clk     = joy_clk_q;
    assign joy_load    = joy_load_q;
    assign joystick    = joystick_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign scan_active = scan_active_q;

endmodule

// File: tb/tb_userio_joy_scan.sv
`timescale 1ns/1ps
module tb_userio_joy_scan;

    localparam int NP    = 2;
    localparam int BPP   = 12;
    localparam int DIV   = 4;
    localparam int GAPT  = 2;
    localparam int TOTAL = NP * BPP;

`ifdef USERIO_JOY_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic             en       = 1'b0;
    logic             joy_data = 1'b1;
    logic             joy_clk;
    logic             joy_load;
    logic [TOTAL-1:0] joystick;
    logic             frame_done;
    logic [7:0]       frame_cnt;
    logic             scan_active;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    userio_joy_scan #(
        .NUM_PLAYERS    (NP),
        .BITS_PER_PLAYER(BPP),
        .CLK_DIV        (DIV),
        .GAP_TICKS      (GAPT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .joy_data   (joy_data),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joystick   (joystick),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .scan_active(scan_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift-register chain model: loads while joy_load is low, shifts on
    // joy_clk rising, drives the current bit inverted (buttons active-low).
    logic [TOTAL-1:0] chain = '0;
    logic [TOTAL-1:0] sh    = '0;
    logic             jclk_d = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!joy_load)               sh = chain;
        else if (joy_clk && !jclk_d) sh = sh >> 1;
        jclk_d   = joy_clk;
        joy_data = ~sh[0];
    end

    // Pin monitor, sampled on the falling edge.
    int cyc = 0, load_fall_cyc = 0, load_rise_cyc = 0, clk_rise_cyc = 0;
    int load_low_len = 0, first_clk_delay = 0, load_period = 0, load_falls = 0;
    int rises = 0, rises_at_load = 0, rises_frame = 0;
    int fd_cnt = 0, fd_minus_load = 0, fd_wide = 0, overlap = 0, bad_hi = 0;
    logic p_load = 1'b1, p_jclk = 1'b0, p_fd = 1'b0, first_pend = 1'b0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!joy_load && joy_clk) overlap++;
        if (p_load && !joy_load) begin
            load_period   = cyc - load_fall_cyc;
            load_fall_cyc = cyc;
            rises_at_load = rises;
            load_falls++;
        end
        if (!p_load && joy_load) begin
            load_low_len  = cyc - load_fall_cyc;
            load_rise_cyc = cyc;
            first_pend    = 1'b1;
        end
        if (!p_jclk && joy_clk) begin
            rises++;
            clk_rise_cyc = cyc;
            if (first_pend) begin
                first_clk_delay = cyc - load_rise_cyc;
                first_pend      = 1'b0;
            end
        end
        if (p_jclk && !joy_clk && reset_n && (cyc - clk_rise_cyc) != DIV) bad_hi++;
        if (frame_done) begin
            fd_cnt++;
            fd_minus_load = cyc - load_fall_cyc;
            rises_frame   = rises - rises_at_load;
            if (p_fd) fd_wide++;
        end
        p_load = joy_load;
        p_jclk = joy_clk;
        p_fd   = frame_done;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fd(input string tag);
        int start;
        int n;
        start = fd_cnt;
        n     = 0;
        while (fd_cnt == start && n < 2000) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, (fd_cnt != start), 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t0, lf0, fd0;

        repeat (3) step();
        check("rst_joy_load",    joy_load,    1);
        check("rst_joy_clk",     joy_clk,     0);
        check("rst_joystick",    joystick,    0);
        check("rst_frame_done",  frame_done,  0);
        check("rst_frame_cnt",   frame_cnt,   0);
        check("rst_scan_active", scan_active, 0);

        // Basic frame and pin timing
        reset_n = 1'b1;
        en      = 1'b1;
        chain   = 24'h5A3C81;
        wait_fd("frame1");
        check("frame1_joystick",   joystick, DEB ? 32'h0 : 32'h5A3C81);
        check("load_low_clks",     load_low_len, DIV);
        check("first_sample_clks", first_clk_delay, DIV);
        check("jclk_rises",        rises_frame, 23);
        check("load_to_done_clks", fd_minus_load, DIV * (1 + 24 + 23) + 1);
        wait_fd("frame2");
        check("frame2_joystick",   joystick, 32'h5A3C81);
        check("frame_period_clks", load_period, DIV * (1 + 24 + 23 + GAPT));
        check("frame2_cnt",        frame_cnt, 2);
        check("gap_scan_active",   scan_active, 1);

        // Glitch and steady-change sequence
        chain = 24'h000001;
        wait_fd("deb_a");
        wait_fd("deb_b");
        check("steady_001", joystick, 32'h1);
        chain = 24'h000801;
        wait_fd("glitch");
        check("glitch_frame", joystick, DEB ? 32'h1 : 32'h801);
        chain = 24'h000001;
        wait_fd("after_glitch");
        check("after_glitch", joystick, 32'h1);
        chain = 24'h000003;
        wait_fd("chg1");
        check("change_frame1", joystick, DEB ? 32'h1 : 32'h3);
        wait_fd("chg2");
        check("change_frame2", joystick, 32'h3);

        // en dropped during bit 10
        chain = 24'h123456;
        wait_fd("endrop_pre");
        lf0 = load_falls;
        n   = 0;
        while (load_falls == lf0 && n < 400) begin step(); n++; end
        n = 0;
        while ((rises - rises_at_load) < 10 && n < 400) begin step(); n++; end
        check("endrop_at_bit10", rises - rises_at_load, 10);
        en = 1'b0;
        wait_fd("endrop");
        check("endrop_joystick", joystick, 32'h123456);
        check("endrop_rises",    rises_frame, 23);
        repeat (30) step();
        check("endrop_idle", scan_active, 0);
        lf0 = load_falls;
        repeat (150) step();
        check("endrop_no_load",   load_falls, lf0);
        check("idle_scan_active", scan_active, 0);
        check("idle_hold_joy",    joystick, 32'h123456);
        en  = 1'b1;
        t0  = cyc;
        lf0 = load_falls;
        n   = 0;
        while (load_falls == lf0 && n < 20) begin step(); n++; end
        check("relaunch_next_tick", (load_falls != lf0) && (load_fall_cyc - t0 >= 1) && (load_fall_cyc - t0 <= DIV), 1);

        // Reset asserted mid-shift with a known value on joystick
        chain = 24'h00ABCD;
        wait_fd("abcd_1");
        wait_fd("abcd_2");
        wait_fd("abcd_3");
        check("abcd_joystick", joystick, 32'hABCD);
        n = 0;
        while (!joy_clk && n < 400) begin step(); n++; end
        check("mid_shift_reached", joy_clk, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_joystick",    joystick,    0);
        check("mid_rst_joy_load",    joy_load,    1);
        check("mid_rst_joy_clk",     joy_clk,     0);
        check("mid_rst_frame_cnt",   frame_cnt,   0);
        check("mid_rst_frame_done",  frame_done,  0);
        check("mid_rst_scan_active", scan_active, 0);
        repeat (3) step();
        reset_n = 1'b1;

        // Counter wrap over 256 frames
        fd0 = fd_cnt;
        n   = 0;
        while ((fd_cnt - fd0) < 255 && n < 256 * 220) begin step(); n++; end
        check("wrap_255", frame_cnt, 255);
        wait_fd("wrap_256");
        check("wrap_0",        frame_cnt, 0);
        check("wrap_pulses",   fd_cnt - fd0, 256);
        check("fd_single_clk", fd_wide, 0);
        check("no_overlap",    overlap, 0);
        check("jclk_high_len", bad_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
